// File: rtl/posit_pkg.sv
// Shared posit helpers: width functions and the decoded-operand record
// consumed by the PDPU stages.
package posit_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int unsigned exp_width(input int unsigned n, input int unsigned es);
    return clog2(n - 1) + es;
  endfunction

  function automatic int unsigned mant_width(input int unsigned n, input int unsigned es);
    return n - es - 3;
  endfunction

  localparam int unsigned N_DEF  = 16;
  localparam int unsigned ES_DEF = 1;

  typedef struct packed {
    logic                                sign;
    logic [exp_width(N_DEF, ES_DEF):0]  rg_exp;
    logic [mant_width(N_DEF, ES_DEF):0] mant_norm;
    logic                                zero;
    logic                                nar;
  } posit_dec_t;

endpackage

// File: rtl/posit_regime_lzc.sv
// Regime run-length counter: length of the run of bits equal to the MSB,
// saturating at the full field width.
module posit_regime_lzc
  import posit_pkg::*;
#(
  parameter int unsigned n  = 16,
  parameter int unsigned CW = clog2(n)
) (
  input  logic [n-2:0]  bits,
  output logic [CW-1:0] run_len
);

  logic [n-2:0] inv;
  logic         done;

  always_comb begin
    inv     = bits[n-2] ? ~bits : bits;
    run_len = '0;
    done    = 1'b0;
    for (int unsigned i = 0; i < n - 1; i++) begin
      if (!done) begin
        if (inv[n-2-i]) done = 1'b1;
        else            run_len = run_len + CW'(1);
      end
    end
  end

endmodule

// File: rtl/posit_decoder_pipe.sv
// Two-stage posit decoder: S1 takes sign/magnitude and regime run length,
// S2 strips the regime and emits combined regime/exponent plus mantissa.
module posit_decoder_pipe
  import posit_pkg::*;
#(
  parameter int unsigned n          = 16,
  parameter int unsigned es         = 1,
  parameter int unsigned nd         = clog2(n - 1),
  parameter int unsigned EXP_WIDTH  = exp_width(n, es),
  parameter int unsigned MANT_WIDTH = mant_width(n, es)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [n-1:0]        posit_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic                sign_o,
  output logic [EXP_WIDTH:0]  rg_exp_o,
  output logic [MANT_WIDTH:0] mant_norm_o,
  output logic                zero_o,
  output logic                nar_o
);

  localparam int unsigned CW = clog2(n);

  logic          s1_v, s1_sign, s1_zero, s1_nar;
  logic [n-2:0]  s1_abs;
  logic [CW-1:0] s1_m;

  logic [n-1:0]  neg;
  logic [n-2:0]  abs_d;
  logic [CW-1:0] m_d;
  logic          zero_d, nar_d;

  logic              s2_en;
  logic [CW:0]       m_ext, k;
  logic [n-2:0]      sh;
  logic [EXP_WIDTH:0] rg_exp_d;
  logic [MANT_WIDTH-1:0] frac;
  logic              special;
  logic              unused_bits;

  assign s2_en      = !out_valid_o || out_ready_i;
  assign in_ready_o = !s1_v || s2_en;

  assign neg    = ~posit_i + n'(1);
  assign abs_d  = posit_i[n-1] ? neg[n-2:0] : posit_i[n-2:0];
  assign zero_d = (posit_i == '0);
  assign nar_d  = (posit_i == {1'b1, {(n-1){1'b0}}});

  posit_regime_lzc #(.n(n), .CW(CW)) u_lzc (
    .bits    (abs_d),
    .run_len (m_d)
  );

  // Shifting out m+1 bits drops regime and terminator; a saturated regime
  // has no terminator and the shift simply leaves nothing behind.
  assign m_ext = {1'b0, s1_m};
  assign k     = s1_abs[n-2] ? (m_ext - (CW+1)'(1)) : ((CW+1)'(0) - m_ext);
  assign sh    = s1_abs << (m_ext + (CW+1)'(1));
  assign frac  = sh[n-2-es -: MANT_WIDTH];

  if (es > 0) begin : g_exp
    assign rg_exp_d = {k[nd:0], sh[n-2 -: es]};
  end else begin : g_noexp
    assign rg_exp_d = k[nd:0];
  end

  assign special     = s1_zero || s1_nar;
  assign unused_bits = ^{neg[n-1], sh[1:0]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_v        <= 1'b0;
      s1_sign     <= 1'b0;
      s1_zero     <= 1'b0;
      s1_nar      <= 1'b0;
      s1_abs      <= '0;
      s1_m        <= '0;
      out_valid_o <= 1'b0;
      sign_o      <= 1'b0;
      rg_exp_o    <= '0;
      mant_norm_o <= '0;
      zero_o      <= 1'b0;
      nar_o       <= 1'b0;
    end else begin
      if (in_ready_o) begin
        s1_v <= in_valid_i;
        if (in_valid_i) begin
          s1_sign <= posit_i[n-1];
          s1_zero <= zero_d;
          s1_nar  <= nar_d;
          s1_abs  <= abs_d;
          s1_m    <= m_d;
        end
      end
      if (s2_en) begin
        out_valid_o <= s1_v;
        if (s1_v) begin
          sign_o      <= s1_sign;
          rg_exp_o    <= special ? '0 : rg_exp_d;
          mant_norm_o <= special ? '0 : {1'b1, frac};
          zero_o      <= s1_zero;
          nar_o       <= s1_nar;
        end
      end
    end
  end

endmodule

// File: tb/tb_posit_decoder_pipe.sv
// Randomised and directed bench for the posit decoder (n=16, es=1) with an
// arithmetic reference decoder and an in-order scoreboard.
module tb_posit_decoder_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] posit;
  logic        out_valid;
  logic        out_ready;
  logic        sign;
  logic [5:0]  rg_exp;
  logic [12:0] mant_norm;
  logic        zero;
  logic        nar;

  int total = 0;
  int bad   = 0;

  logic [21:0] q[$];
  bit          acc_d1 = 0, acc_d2 = 0;
  int          lat_ok = 0;
  bit          lat_mode = 0;

  always #5 clk = ~clk;

  posit_decoder_pipe #(.n(16), .es(1)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .posit_i     (posit),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .sign_o      (sign),
    .rg_exp_o    (rg_exp),
    .mant_norm_o (mant_norm),
    .zero_o      (zero),
    .nar_o       (nar)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Packed as {sign, rg_exp[5:0], mant_norm[12:0], zero, nar}.
  function automatic logic [21:0] ref_decode(input logic [15:0] p);
    int a, m, k, rem, ex, fr, rest, rg;
    int r0;
    bit s;
    if (p == 16'h0000) return {1'b0, 6'd0, 13'd0, 1'b1, 1'b0};
    if (p == 16'h8000) return {1'b1, 6'd0, 13'd0, 1'b0, 1'b1};
    s  = p[15];
    a  = s ? ((65536 - int'(p)) % 65536) : int'(p);
    a  = a % 32768;
    r0 = (a >> 14) & 1;
    m  = 0;
    while (m < 15 && ((a >> (14 - m)) & 1) == r0) m++;
    k   = (r0 == 1) ? m - 1 : -m;
    rem = 15 - m - 1;
    if (rem < 0) rem = 0;
    rest = a % (1 << rem);
    ex = 0;
    fr = 0;
    if (rem >= 1) begin
      ex = rest >> (rem - 1);
      fr = (rest % (1 << (rem - 1))) << (12 - (rem - 1));
    end
    rg = k * 2 + ex;
    return {s, 6'(rg), 1'b1, 12'(fr), 2'b00};
  endfunction

  task automatic step(input bit v, input logic [15:0] p, input bit rdy, output bit acc);
    logic [21:0] e;
    @(negedge clk);
    in_valid  = v;
    posit     = p;
    out_ready = rdy;
    #1;
    if (lat_mode && rdy) lat_ok++;
    else lat_ok = 0;
    check_eq("in_ready", in_ready, (q.size() < 2) || rdy);
    if (lat_ok >= 3) check_eq("latency", out_valid, acc_d2);
    if (q.size() == 2) check_eq("full_valid", out_valid, 1);
    if (out_valid) begin
      if (q.size() == 0) check_eq("spurious", out_valid, 0);
      else begin
        e = q[0];
        check_eq("sign", sign, e[21]);
        check_eq("rg_exp", rg_exp, e[20:15]);
        check_eq("mant", mant_norm, e[14:2]);
        check_eq("zero", zero, e[1]);
        check_eq("nar", nar, e[0]);
        if (rdy) void'(q.pop_front());
      end
    end
    acc    = v && in_ready;
    acc_d2 = acc_d1;
    acc_d1 = acc;
    if (acc) q.push_back(ref_decode(p));
  endtask

  function automatic logic [15:0] rand_posit();
    logic [15:0] sp[6];
    sp = '{16'h0000, 16'h8000, 16'h7FFF, 16'h0001, 16'h8001, 16'hFFFF};
    if ($urandom_range(0, 7) == 0) return sp[$urandom_range(0, 5)];
    return 16'($urandom);
  endfunction

  logic [15:0] dir[9];
  logic [15:0] words[4];
  bit acc;
  int idx, stalled_acc;

  initial begin
    dir = '{16'h4000, 16'h5000, 16'h4800, 16'hC000, 16'h7FFF,
            16'h0001, 16'h8001, 16'h0000, 16'h8000};
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    posit     = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_rg_exp", rg_exp, 0);
    check_eq("rst_mant", mant_norm, 0);
    check_eq("rst_flags", {sign, zero, nar}, 0);
    rst_n = 1'b1;
    #1;
    check_eq("rst_in_ready", in_ready, 1);

    lat_mode = 1;
    foreach (dir[i]) step(1, dir[i], 1, acc);
    repeat (3) step(0, '0, 1, acc);
    lat_mode = 0;

    foreach (words[i]) words[i] = rand_posit();
    idx = 0;
    stalled_acc = 0;
    for (int c = 0; c < 20 && idx < 4; c++) begin
      step(1, words[idx], c >= 6, acc);
      if (acc) begin
        idx++;
        if (c < 6) stalled_acc++;
      end
    end
    check_eq("bp_stalled_accepts", stalled_acc, 2);
    check_eq("bp_all_accepted", idx, 4);
    for (int c = 0; c < 10 && q.size() > 0; c++) step(0, '0, 1, acc);
    check_eq("bp_drained", q.size(), 0);

    step(1, rand_posit(), 0, acc);
    step(1, rand_posit(), 0, acc);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_valid", out_valid, 0);
    q.delete();
    acc_d1   = 0;
    acc_d2   = 0;
    lat_ok   = 0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    lat_mode = 1;
    step(1, rand_posit(), 1, acc);
    repeat (3) step(0, '0, 1, acc);
    lat_mode = 0;

    for (int c = 0; c < 3000; c++)
      step($urandom_range(0, 3) != 0, rand_posit(), $urandom_range(0, 3) != 0, acc);
    for (int c = 0; c < 10 && q.size() > 0; c++) step(0, '0, 1, acc);
    check_eq("final_drain", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/posit_decoder_pipe.md
Name: posit_decoder_pipe

Overview:
- Pipelined posit-to-internal decoder; the inverse of the unit's posit encoder.
- Splits an n-bit posit into sign, combined signed regime/exponent, and normalised mantissa with explicit hidden bit.
- Field formats match what the encoder consumes, so decode followed by encode returns the original word.
- Sits at the PDPU operand input; two register stages; valid/ready handshake on both sides.

Parameters:
- n, 16, posit word width.
- es, 1, exponent field width (es = 0 supported).
- nd, clog2(n-1), regime-count width.
- EXP_WIDTH, nd+es, rg_exp width excluding sign bit.
- MANT_WIDTH, n-es-3, fraction width excluding hidden bit.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- in_valid_i  in  1  posit_i valid.
- in_ready_o  out  1  decoder accepts posit_i this cycle.
- posit_i  in  n  posit operand.
- out_valid_o  out  1  output fields valid.
- out_ready_i  in  1  downstream accepts.
- sign_o  out  1  sign.
- rg_exp_o  out  EXP_WIDTH+1  signed k*2^es + exp.
- mant_norm_o  out  MANT_WIDTH+1  {hidden bit, fraction}, MSB-aligned.
- zero_o  out  1  operand is zero.
- nar_o  out  1  operand is NaR.

Behaviour:
- Reset:
  - Asynchronous on rst_ni low; clears both stage valids.
  - out_valid_o=0; all data outputs 0.
  - in_ready_o=1 once reset is released.
  - Reset mid-operation discards any in-flight data; no output is produced for it.
- Stage 1 (S1): registers the following when in_valid_i && in_ready_o:
  - sign = posit_i[n-1].
  - abs = sign ? (~posit_i + 1)[n-2:0] : posit_i[n-2:0].
  - Zero/NaR flags: zero when posit_i == 0; NaR when posit_i == {1, 0...}.
  - r0 = abs[n-2].
  - m = run length of bits equal to r0, counted from abs[n-2] downward, saturating at n-1.
- Stage 2 (S2):
  - k = r0 ? m-1 : -m.
  - Left-shift abs by m+1, dropping the regime and its terminator. A missing terminator is the saturated case.
  - Top es bits become exp, zero-padded if truncated.
  - The next MANT_WIDTH bits become the fraction, zero-padded.
  - rg_exp = (k << es) | exp, sign-extended to EXP_WIDTH+1.
  - mant_norm = {1, fraction}.
- Special values:
  - Zero: sign_o=0, rg_exp_o=0, mant_norm_o=0, zero_o=1.
  - NaR: sign_o=1, rg_exp_o=0, mant_norm_o=0, nar_o=1.
  - zero_o and nar_o are never both 1.
- Latency and throughput:
  - Exactly 2 cycles from accept to out_valid_o when out_ready_i=1.
  - Throughput of 1 word per cycle.
- Handshake:
  - Each stage advances when its successor is empty or being drained.
  - in_ready_o = !s1_v | !s2_v | out_ready_i (combinational).
  - Transfer occurs when valid && ready.
  - While out_valid_o && !out_ready_i, all outputs are held stable.
  - Up to 2 words are buffered; in_ready_o=0 when both stages are full and out_ready_i=0.
  - Simultaneous accept and drain in the same cycle must not drop or duplicate a word.
- Width rules:
  - Range for n=16, es=1: k in [-14, 14]; rg_exp in [-28, 28]; fits EXP_WIDTH+1 = 6 bits.
  - minpos and maxpos are decoded exactly; no rounding is performed.

Decomposition:
- posit_pkg additions:
  - clog2 (already present).
  - localparam-style helper functions for EXP_WIDTH and MANT_WIDTH.
  - Struct posit_dec_t {sign, rg_exp, mant_norm, zero, nar}, for reuse by PDPU stages.
- One sub-module: posit_regime_lzc.
  - Combinational run-length counter over n-1 bits.
  - Inverts the input when r0=1, then counts leading zeros, saturating at n-1.
  - Instantiated in S1.
- Reuse the existing barrel_shifter, left mode, for the S2 shift.

Test Plan:
- n=16, es=1, out_ready_i=1, posits 0x4000, 0x5000, 0x4800, then 0xC000 -> 2 cycles later, one per cycle, (sign, rg_exp, mant_norm):
  - 0x4000 -> (0, 0, 0x1000)
  - 0x5000 -> (0, 1, 0x1000)
  - 0x4800 -> (0, 0, 0x1800)
  - 0xC000 -> (1, 0, 0x1000)
- Extremes:
  - 0x7FFF -> rg_exp=28, mant=0x1000.
  - 0x0001 -> rg_exp=-28, mant=0x1000.
  - 0x8001 -> sign=1, rg_exp=28.
- Special values:
  - 0x0000 -> zero_o=1, mant=0.
  - 0x8000 -> nar_o=1, sign=1, mant=0.
- Backpressure:
  - Stream 4 words with out_ready_i=0 -> in_ready_o drops after 2 accepts; outputs stay stable.
  - Release out_ready_i -> all 4 words emerge in order, none lost or duplicated.
- Reset mid-stream:
  - Assert rst_ni low asynchronously with both stages full -> out_valid_o=0 immediately.
  - After release, the first new word appears 2 cycles after accept.
- Round trip: random posits through decoder then the existing encoder -> bit-exact match; repeat for es=0 and es=2.
